// File: rtl/cp0_timer_intr.sv
// rtl/cp0_timer_intr.sv - CP0 Count/Compare timer, Cause.IP, interrupt request and exception redirect
module cp0_timer_intr #(
  parameter int          COUNT_DIV      = 2,
  parameter logic [31:0] EXC_VEC_NORMAL = 32'h80000180,
  parameter logic [31:0] EXC_VEC_BOOT   = 32'hbfc00380,
  parameter logic [31:0] INT_VEC_OFFSET = 32'h00000080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int,
  input  logic [31:0] cp0_status,
  input  logic        cp0_cause_iv,
  input  logic [1:0]  cp0_cause_sw,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_errorepc,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  input  logic        commit_valid,
  input  logic        commit_exc,
  input  logic [4:0]  commit_code,
  input  logic        commit_eret,
  output logic        int_req,
  output logic [7:0]  cause_ip,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_TAKEN = 2'd2
  } state_t;

  // Prescaler wide enough for COUNT_DIV up to 16 (max value 15).
  localparam logic [3:0] PRESCALE_LAST = 4'(COUNT_DIV - 1);

  logic [5:0]  ext_s1;
  logic [5:0]  ext_s;
  logic [3:0]  prescaler;
  logic        ti;
  logic        tick;
  logic [31:0] count_inc;
  logic        pend;
  logic        commit_int;
  logic [31:0] exc_base;
  state_t      state;

  logic status_ie, status_exl, status_erl, status_bev;
  logic [7:0] status_im;
  logic unused_status;

  assign status_ie     = cp0_status[0];
  assign status_exl    = cp0_status[1];
  assign status_erl    = cp0_status[2];
  assign status_im     = cp0_status[15:8];
  assign status_bev    = cp0_status[22];
  assign unused_status = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:3]};

  assign tick       = (prescaler == PRESCALE_LAST);
  assign count_inc  = count + 32'd1;
  assign cause_ip   = {ti | ext_s[5], ext_s[4:0], cp0_cause_sw};
  assign pend       = status_ie & ~status_exl & ~status_erl & (|(cause_ip & status_im));
  assign commit_int = commit_valid & commit_exc & (commit_code == 5'd0);
  assign exc_base   = status_bev ? EXC_VEC_BOOT : EXC_VEC_NORMAL;

  // Two-flop synchronizer for the asynchronous hardware interrupt lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_s1 <= 6'd0;
      ext_s  <= 6'd0;
    end else begin
      ext_s1 <= ext_int;
      ext_s  <= ext_s1;
    end
  end

  // Count/Compare timer: prescaled Count increment, software loads, and the TI flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= 4'd0;
      count     <= 32'd0;
      compare   <= 32'd0;
      ti        <= 1'b0;
    end else begin
      if (count_wr) begin
        count     <= wr_data;
        prescaler <= 4'd0;
      end else if (tick) begin
        count     <= count_inc;
        prescaler <= 4'd0;
      end else begin
        prescaler <= prescaler + 4'd1;
      end

      // A Compare write acknowledges the timer interrupt and beats a same-cycle match.
      if (compare_wr) begin
        compare <= wr_data;
        ti      <= 1'b0;
      end else if (!count_wr && tick && (count_inc == compare)) begin
        ti <= 1'b1;
      end
    end
  end

  // Interrupt request handshake with writeback; TAKEN waits for committed EXL to avoid re-requesting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      int_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend) begin
            state   <= S_PEND;
            int_req <= 1'b1;
          end else begin
            int_req <= 1'b0;
          end
        end
        S_PEND: begin
          if (commit_int) begin
            state   <= S_TAKEN;
            int_req <= 1'b0;
          end else if (!pend) begin
            state   <= S_IDLE;
            int_req <= 1'b0;
          end else begin
            int_req <= 1'b1;
          end
        end
        S_TAKEN: begin
          int_req <= 1'b0;
          if (status_exl) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

  // Front-end redirect after a committed exception (priority) or ERET; one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      if (commit_valid && commit_exc) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= exc_base + ((commit_code == 5'd0 && cp0_cause_iv) ? INT_VEC_OFFSET : 32'd0);
      end else if (commit_valid && commit_eret) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= status_erl ? cp0_errorepc : cp0_epc;
      end else begin
        redirect_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_intr.sv
// tb/tb_cp0_timer_intr.sv - self-checking bench for cp0_timer_intr against a behavioural model
module tb_cp0_timer_intr;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ext_int;
  logic [31:0] cp0_status;
  logic        cp0_cause_iv;
  logic [1:0]  cp0_cause_sw;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_errorepc;
  logic        count_wr;
  logic        compare_wr;
  logic [31:0] wr_data;
  logic        commit_valid;
  logic        commit_exc;
  logic [4:0]  commit_code;
  logic        commit_eret;
  logic        int_req;
  logic [7:0]  cause_ip;
  logic [31:0] count;
  logic [31:0] compare;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_count, m_compare, m_rpc;
  logic        m_ti, m_int_req, m_wait_exl, m_rv;
  logic [5:0]  m_s1, m_s2;
  int          m_since;

  cp0_timer_intr #(.COUNT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .ext_int(ext_int), .cp0_status(cp0_status),
    .cp0_cause_iv(cp0_cause_iv), .cp0_cause_sw(cp0_cause_sw), .cp0_epc(cp0_epc),
    .cp0_errorepc(cp0_errorepc), .count_wr(count_wr), .compare_wr(compare_wr),
    .wr_data(wr_data), .commit_valid(commit_valid), .commit_exc(commit_exc),
    .commit_code(commit_code), .commit_eret(commit_eret), .int_req(int_req),
    .cause_ip(cause_ip), .count(count), .compare(compare),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_cause_ip();
    return {m_ti | m_s2[5], m_s2[4:0], cp0_cause_sw};
  endfunction

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_ti = 0; m_since = 0;
    m_s1 = 0; m_s2 = 0; m_int_req = 0; m_wait_exl = 0; m_rv = 0; m_rpc = 0;
  endtask

  // One clock edge of the architectural rules, evaluated on pre-edge values.
  task automatic model_edge();
    logic [7:0] cip;
    logic       pend;
    logic       tick;
    cip  = model_cause_ip();
    pend = cp0_status[0] && !cp0_status[1] && !cp0_status[2] && ((cip & cp0_status[15:8]) != 0);

    if (m_wait_exl) begin
      m_int_req = 0;
      if (cp0_status[1]) m_wait_exl = 0;
    end else if (m_int_req && commit_valid && commit_exc && commit_code == 0) begin
      m_int_req  = 0;
      m_wait_exl = 1;
    end else begin
      m_int_req = pend;
    end

    tick = 0;
    if (count_wr) begin
      m_count = wr_data;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since % DIV == 0) begin
        m_count = m_count + 1;
        tick = 1;
      end
    end
    if (compare_wr) begin
      m_ti = 0;
    end else if (tick && m_count == m_compare) begin
      m_ti = 1;
    end
    if (compare_wr) m_compare = wr_data;

    if (commit_valid && commit_exc) begin
      m_rv  = 1;
      m_rpc = (cp0_status[22] ? 32'hbfc00380 : 32'h80000180) +
              ((commit_code == 0 && cp0_cause_iv) ? 32'h80 : 32'h0);
    end else if (commit_valid && commit_eret) begin
      m_rv  = 1;
      m_rpc = cp0_status[2] ? cp0_errorepc : cp0_epc;
    end else begin
      m_rv = 0;
    end

    m_s2 = m_s1;
    m_s1 = ext_int;
  endtask

  task automatic check_all();
    chk("int_req", int_req, m_int_req);
    chk("cause_ip", cause_ip, model_cause_ip());
    chk("count", count, m_count);
    chk("compare", compare, m_compare);
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic quiet();
    count_wr = 0; compare_wr = 0; commit_valid = 0; commit_exc = 0;
    commit_code = 0; commit_eret = 0;
  endtask

  // Inputs are set at the falling edge before calling; checks happen at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    quiet();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    chk("rst_int_req", int_req, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_compare", compare, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_all();
  endtask

  initial begin
    reset = 0; ext_int = 0; cp0_status = 0; cp0_cause_iv = 0; cp0_cause_sw = 0;
    cp0_epc = 0; cp0_errorepc = 0; wr_data = 0;
    quiet();
    model_reset();
    do_reset();

    // Timer interrupt, then Int commit with IV=1
    cp0_status = 32'h0000_8001; cp0_cause_iv = 1;
    count_wr = 1; wr_data = 0; step();
    compare_wr = 1; wr_data = 5; step();
    for (int i = 0; i < 20; i++) begin
      if (int_req) break;
      step();
    end
    chk("timer_int_req", int_req, 1);
    chk("timer_ti", cause_ip[7], 1);
    step(); step();
    chk("int_req_held", int_req, 1);
    commit_valid = 1; commit_exc = 1; commit_code = 0; step();
    chk("int_redirect_valid", redirect_valid, 1);
    chk("int_redirect_pc", redirect_pc, 32'h80000200);
    chk("taken_int_req", int_req, 0);
    step(); step(); step();
    chk("taken_hold", int_req, 0);
    cp0_status = 32'h0000_8003; step(); step();
    cp0_status = 32'h0000_8001; compare_wr = 1; wr_data = 32'h100; step();
    step(); step();

    // Compare write in the same cycle as a match: clear wins
    compare_wr = 1; wr_data = 3; step();
    count_wr = 1; wr_data = 0; step();
    for (int i = 0; i < 5; i++) step();
    compare_wr = 1; wr_data = 3; step();
    chk("same_cycle_count", count, 3);
    chk("same_cycle_ti", cause_ip[7], 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("same_cycle_no_req", int_req, 0);
    end

    // Count wraparound without spurious TI
    compare_wr = 1; wr_data = 32'h1234; step();
    count_wr = 1; wr_data = 32'hFFFF_FFFF; step();
    chk("wrap_load", count, 32'hFFFF_FFFF);
    step(); step();
    chk("wrap_zero", count, 0);
    chk("wrap_no_ti", cause_ip[7], 0);

    // ERET redirects
    cp0_status = 32'h0; cp0_epc = 32'hbfc00100; cp0_errorepc = 32'h80001000;
    commit_valid = 1; commit_eret = 1; step();
    chk("eret_valid", redirect_valid, 1);
    chk("eret_epc", redirect_pc, 32'hbfc00100);
    step();
    chk("eret_pulse", redirect_valid, 0);
    chk("eret_hold_pc", redirect_pc, 32'hbfc00100);
    cp0_status = 32'h4; commit_valid = 1; commit_eret = 1; step();
    chk("eret_errorepc", redirect_pc, 32'h80001000);

    // External interrupt through the synchronizer, withdrawal, and reset mid-PEND
    cp0_status = 32'h0000_1001; ext_int = 6'b000100; step();
    step();
    chk("ext_cause_ip4", cause_ip[4], 1);
    step();
    chk("ext_int_req", int_req, 1);
    cp0_status = 32'h0000_0001; step();
    chk("ext_withdraw", int_req, 0);
    cp0_status = 32'h0000_1001; step(); step();
    chk("ext_rerequest", int_req, 1);
    do_reset();
    ext_int = 0;
    step(); step();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1000 || cyc == 2000) do_reset();
      if ($urandom_range(0, 7) == 0) begin
        cp0_status = 32'h0;
        cp0_status[0]     = ($urandom_range(0, 99) < 80);
        cp0_status[1]     = ($urandom_range(0, 99) < 15);
        cp0_status[2]     = ($urandom_range(0, 99) < 8);
        cp0_status[15:8]  = 8'($urandom);
        cp0_status[22]    = 1'($urandom_range(0, 1));
        cp0_cause_iv      = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0)  ext_int = 6'($urandom);
      if ($urandom_range(0, 15) == 0) cp0_cause_sw = 2'($urandom);
      cp0_epc      = $urandom;
      cp0_errorepc = $urandom;
      count_wr     = ($urandom_range(0, 49) == 0);
      compare_wr   = ($urandom_range(0, 29) == 0);
      if (count_wr) begin
        case ($urandom_range(0, 2))
          0: wr_data = $urandom;
          1: wr_data = 32'hFFFF_FFFE;
          default: wr_data = m_count;
        endcase
      end else begin
        wr_data = m_count + 32'($urandom_range(0, 6));
      end
      commit_valid = ($urandom_range(0, 2) == 0);
      commit_exc   = ($urandom_range(0, 3) == 0);
      commit_code  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      commit_eret  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
